// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operation codes, FSM state encoding and default data width.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

    // Default operand / HI / LO width (only 32 is supported)
    localparam int c_DATA_W_DEF = 32;

    // Operation codes presented on md_unit.op
    localparam logic [2:0] c_MD_MULT  = 3'b000;
    localparam logic [2:0] c_MD_MULTU = 3'b001;
    localparam logic [2:0] c_MD_DIV   = 3'b010;
    localparam logic [2:0] c_MD_DIVU  = 3'b011;
    localparam logic [2:0] c_MD_MTHI  = 3'b100;
    localparam logic [2:0] c_MD_MTLO  = 3'b101;
    // 3'b110 and 3'b111 are reserved and ignored by the unit

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_CALC = 2'b01;
    localparam logic [1:0] c_ST_FIX  = 2'b10;

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Iterative multiply/divide unit holding the HI/LO registers.
//               mult/multu use shift-add, div/divu use restoring division,
//               one bit per cycle, followed by a single sign-fix cycle.
//               mthi/mtlo write HI/LO directly while idle.
// Ports       : clk   - clock, all state changes on rising edge
//               rst   - synchronous active-high reset
//               start - one-cycle request strobe, sampled only when idle
//               op    - operation code (md_pkg c_MD_*)
//               op_a  - rs operand: multiplicand / dividend / mthi-mtlo data
//               op_b  - rt operand: multiplier / divisor
//               busy  - high while a mult/div is in progress
//               done  - one-cycle pulse, new mult/div result is in hi/lo
//               hi    - HI register
//               lo    - LO register
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import md_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int ITERS  = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int                 c_CNT_W = $clog2(ITERS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(ITERS - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_is_div;
    logic                r_neg_res;   // product / quotient must be negated
    logic                r_neg_rem;   // remainder takes the dividend's sign
    logic [DATA_W-1:0]   r_opnd;      // multiplicand or divisor magnitude
    // Mult: {partial product, remaining multiplier bits}
    // Div : {partial remainder, dividend bits / quotient bits}
    logic [2*DATA_W-1:0] r_acc;
    logic                r_done;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    // ---------------- operand conditioning ----------------
    logic              w_op_md;
    logic              w_op_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_abs;
    logic [DATA_W-1:0] w_b_abs;

    assign w_op_md     = (op == c_MD_MULT) || (op == c_MD_MULTU) ||
                         (op == c_MD_DIV)  || (op == c_MD_DIVU);
    assign w_op_signed = (op == c_MD_MULT) || (op == c_MD_DIV);
    assign w_a_neg     = w_op_signed && op_a[DATA_W-1];
    assign w_b_neg     = w_op_signed && op_b[DATA_W-1];
    assign w_a_abs     = w_a_neg ? (-op_a) : op_a;
    assign w_b_abs     = w_b_neg ? (-op_b) : op_b;

    // ---------------- shift-add step ----------------
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_nxt;

    assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} +
                       {1'b0, (r_acc[0] ? r_opnd : {DATA_W{1'b0}})};
    // Carry out of the add becomes the new product MSB as everything shifts right
    assign w_mul_nxt = {w_mul_sum, r_acc[DATA_W-1:1]};

    // ---------------- restoring divide step ----------------
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W-1:0]   w_rem_sub;
    logic                w_q_bit;
    logic [DATA_W-1:0]   w_rem_nxt;
    logic [2*DATA_W-1:0] w_div_nxt;

    assign w_rem_sh  = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    assign w_q_bit   = (w_rem_sh >= {1'b0, r_opnd});
    // When the subtraction is taken the result is below the divisor, so the
    // low DATA_W bits of the difference are exact.
    assign w_rem_sub = w_rem_sh[DATA_W-1:0] - r_opnd;
    assign w_rem_nxt = w_q_bit ? w_rem_sub : w_rem_sh[DATA_W-1:0];
    assign w_div_nxt = {w_rem_nxt, r_acc[DATA_W-2:0], w_q_bit};

    // ---------------- sign correction ----------------
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_res ? (-r_acc) : r_acc;
    assign w_quo_fix  = r_neg_res ? (-r_acc[DATA_W-1:0]) : r_acc[DATA_W-1:0];
    assign w_rem_fix  = r_neg_rem ? (-r_acc[2*DATA_W-1:DATA_W])
                                  : r_acc[2*DATA_W-1:DATA_W];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start && w_op_md) w_state_nxt = c_ST_CALC;
            c_ST_CALC: if (r_cnt == c_LAST)  w_state_nxt = c_ST_FIX;
            c_ST_FIX:  w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        if (op == c_MD_MTHI) begin
                            r_hi <= op_a;
                        end else if (op == c_MD_MTLO) begin
                            r_lo <= op_a;
                        end else if (w_op_md) begin
                            r_is_div  <= op[1];
                            r_neg_res <= w_a_neg ^ w_b_neg;
                            r_neg_rem <= w_a_neg;
                            r_cnt     <= '0;
                            r_opnd    <= op[1] ? w_b_abs : w_a_abs;
                            r_acc     <= {{DATA_W{1'b0}}, (op[1] ? w_a_abs : w_b_abs)};
                        end
                    end
                end
                c_ST_CALC: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
                end
                c_ST_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*DATA_W-1:DATA_W];
                        r_lo <= w_prod_fix[DATA_W-1:0];
                    end
                    r_done <= 1'b1;
                    r_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != c_ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule : md_unit
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit. A table of operations with
//               expected HI/LO is applied in order; mult/div results are
//               queued when started and compared when done pulses. Extra
//               sequences cover strobes while busy and reset mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit #(.DATA_W(32), .ITERS(32)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Compare a done pulse against the oldest queued expectation
    task automatic pop_compare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, "_hi"}, hi, e.hi);
            check({name, "_lo"}, lo, e.lo);
        end
    endtask

    // Called at a negedge; returns at the negedge where the result is visible
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        int   bcnt;
        logic seen;
        start = 1'b1; op = o; op_a = a; op_b = b;
        if (o <= c_MD_DIVU) begin
            e.hi = eh; e.lo = el;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        if (o <= c_MD_DIVU) begin
            bcnt = 0;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                if (busy) bcnt++;
                @(negedge clk);
            end
            check({name, "_done"}, {31'd0, seen}, 32'd1);
            check({name, "_busy_cycles"}, bcnt, 32'd33);
            check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            if (seen) pop_compare(name);
        end else begin
            check({name, "_hi"}, hi, eh);
            check({name, "_lo"}, lo, el);
            check({name, "_busy"}, {31'd0, busy}, 32'd0);
            check({name, "_done"}, {31'd0, done}, 32'd0);
        end
    endtask

    vec_t vecs[15];

    initial begin
        int pulses;

        vecs[0]  = '{c_MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{c_MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{c_MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{c_MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[4]  = '{c_MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{c_MD_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h80000000};
        vecs[6]  = '{c_MD_MTLO,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0};
        vecs[7]  = '{3'b111,     32'h55555555, 32'h0,        32'h12345678, 32'h9ABCDEF0};
        vecs[8]  = '{3'b110,     32'hAAAAAAAA, 32'h1,        32'h12345678, 32'h9ABCDEF0};
        vecs[9]  = '{c_MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{c_MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[11] = '{c_MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
        vecs[12] = '{c_MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
        vecs[13] = '{c_MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[14] = '{c_MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        rst = 1'b1; start = 1'b0; op = 3'b000; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_hi",   hi, 32'h0);
        check("reset_lo",   lo, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        // Each op is issued in the cycle where the previous result appears
        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Strobes while busy must be ignored; HI/LO hold until the result
        begin
            exp_t e;
            e.hi = 32'd2; e.lo = 32'd14;
            sb.push_back(e);
            start = 1'b1; op = c_MD_DIVU; op_a = 32'd100; op_b = 32'd7;
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            start = 1'b1; op = c_MD_MTHI; op_a = 32'h0000DEAD;
            @(negedge clk);
            check("busy_mthi_hi", hi, 32'h40000000);
            op = c_MD_MULT; op_a = 32'd3; op_b = 32'd3;
            @(negedge clk);
            start = 1'b0;
            check("busy_hold_hi", hi, 32'h40000000);
            check("busy_hold_lo", lo, 32'h00000000);
            pulses = 0;
            for (int i = 0; i < 60; i++) begin
                if (done) begin
                    pulses++;
                    pop_compare("busy_strobe");
                end
                @(negedge clk);
            end
            check("busy_strobe_pulses", pulses, 32'd1);
            check("busy_strobe_idle", {31'd0, busy}, 32'd0);
        end

        // Reset during CALC aborts the operation without a done pulse
        start = 1'b1; op = c_MD_MULTU; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi",   hi, 32'h0);
        check("abort_lo",   lo, 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("abort_no_done", pulses, 32'd0);
        run_op("after_abort", c_MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_md_unit
`default_nettype wire
